// File: rtl/booth_r4_mul.sv
// Iterative radix-4 Booth multiplier: retires two multiplier bits per cycle.
// Valid/ready on both sides; one multiply in flight at a time.
module booth_r4_mul #(
  parameter int N = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  input  logic           signed_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*N-1:0] y_o,
  output logic           busy_o
);

  localparam int K  = N / 2 + 1;
  localparam int MW = N + 2;        // extended operand width
  localparam int AW = 2 * N + 4;    // accumulator width
  localparam int CW = $clog2(K + 1);

  if ((N % 2) != 0 || N < 4) begin : g_bad_n
    $error("booth_r4_mul: N must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [MW-1:0]   m_q, m_d;        // extended multiplicand
  logic [MW:0]     b_q, b_d;        // extended multiplier with b[-1] in bit 0
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  y_q, y_d;

  logic [2:0]      trip;
  logic            neg;
  logic [MW:0]     mag;
  logic [MW:0]     pp;
  logic [AW-1:0]   acc_step;

  // Booth recoding of the current triplet. Negative selections use the
  // one's complement of the magnitude plus a carry-in at the same weight.
  always_comb begin
    trip = b_q[2:0];
    neg  = trip[2] & ~(trip[1] & trip[0]);
    case (trip)
      3'b001, 3'b010, 3'b101, 3'b110: mag = {m_q[MW-1], m_q};
      3'b011, 3'b100:                 mag = {m_q, 1'b0};
      default:                        mag = '0;
    endcase
    pp = neg ? ~mag : mag;
    // Adding at weight 2^MW and then shifting right 2 equals shifting first and
    // adding at 2^N: the partial product has no bits below the dropped pair.
    acc_step = {{2{acc_q[AW-1]}}, acc_q[AW-1:2]}
             + ({{(AW-MW-1){pp[MW]}}, pp} << N)
             + (AW'(neg) << N);
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          m_d     = signed_i ? {{2{a_i[N-1]}}, a_i} : {2'b00, a_i};
          b_d     = {(signed_i ? {{2{b_i[N-1]}}, b_i} : {2'b00, b_i}), 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // After K iterations the accumulator is exact; one more cycle moves it to y.
        if (cnt_q == CW'(K)) begin
          y_d     = acc_q[2*N-1:0];
          state_d = DONE;
        end else begin
          acc_d = acc_step;
          b_d   = {2'b00, b_q[MW:2]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      m_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign y_o         = y_q;

endmodule

// File: tb/tb_booth_r4_mul.sv
// Bench for booth_r4_mul: N=8 and N=16 instances against an arithmetic product
// model, with handshake, latency and result-hold monitoring on every cycle.
module tb_booth_r4_mul;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic        iv0, ir0, ov0, or0, s0, bz0;
  logic [7:0]  a0, b0;
  logic [15:0] y0;
  logic        iv1, ir1, ov1, or1, s1, bz1;
  logic [15:0] a1, b1;
  logic [31:0] y1;

  booth_r4_mul #(.N(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(iv0), .in_ready_o(ir0),
    .a_i(a0), .b_i(b0), .signed_i(s0), .out_valid_o(ov0),
    .out_ready_i(or0), .y_o(y0), .busy_o(bz0)
  );

  booth_r4_mul #(.N(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(iv1), .in_ready_o(ir1),
    .a_i(a1), .b_i(b1), .signed_i(s1), .out_valid_o(ov1),
    .out_ready_i(or1), .y_o(y1), .busy_o(bz1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference product from plain integer arithmetic, truncated to 2n bits.
  function automatic logic [31:0] ref_prod(input int n, input logic [15:0] a, b, input logic sg);
    longint sa, sb, p, mask;
    sa = {48'b0, a};
    sb = {48'b0, b};
    if (sg && a[n-1]) sa = sa - (longint'(1) << n);
    if (sg && b[n-1]) sb = sb - (longint'(1) << n);
    p    = sa * sb;
    mask = (longint'(1) << (2 * n)) - 1;
    p    = p & mask;
    return p[31:0];
  endfunction

  // Per-instance monitor state (index 0: N=8, index 1: N=16).
  int          cyc = 0;
  bit          armed [2];
  bit          rst_pend [2];
  bit          pending [2];
  bit          idle_after [2];
  bit          prev_ov [2];
  int          acc_cyc [2];
  int          done_cnt [2];
  logic [31:0] exp_y [2];
  logic [31:0] last_y [2];

  // Sampled on the falling edge: values seen here are what the next rising edge uses.
  task automatic monitor(input int id, input int n, input logic iv, ir, ov, ordy, bz, sg,
                         input logic [15:0] a, b, input logic [31:0] y);
    int k;
    k = n / 2 + 1;
    if (rst_pend[id]) begin
      check("rst_in_ready", ir, 1'b1);
      check("rst_out_valid", ov, 1'b0);
      check("rst_busy", bz, 1'b0);
      check("rst_y", y, 32'h0);
      rst_pend[id] = 1'b0;
      armed[id]    = 1'b1;
    end
    if (rst_i === 1'b0) begin
      rst_pend[id]   = 1'b1;
      pending[id]    = 1'b0;
      idle_after[id] = 1'b0;
      prev_ov[id]    = 1'b0;
      last_y[id]     = 32'h0;
      return;
    end
    if (!armed[id]) return;
    check("busy_vs_ready", bz, !ir);
    if (idle_after[id]) begin
      check("idle_after_handshake", {ir, ov}, 2'b10);
      idle_after[id] = 1'b0;
    end
    if (ov) begin
      if (!pending[id]) check("spurious_out_valid", ov, 1'b0);
      else begin
        if (!prev_ov[id]) check("latency", cyc - acc_cyc[id], k + 2);
        check("product", y, exp_y[id]);
      end
    end else begin
      check("y_held", y, last_y[id]);
      if (pending[id] && (cyc - acc_cyc[id] > k + 2)) begin
        check("result_timeout", ov, 1'b1);
        pending[id] = 1'b0;
      end
    end
    if (ov && ordy && pending[id]) begin
      last_y[id]     = exp_y[id];
      pending[id]    = 1'b0;
      idle_after[id] = 1'b1;
      done_cnt[id]++;
    end
    if (iv && ir) begin
      if (pending[id]) check("accept_while_pending", ir, 1'b0);
      pending[id] = 1'b1;
      exp_y[id]   = ref_prod(n, a, b, sg);
      acc_cyc[id] = cyc;
    end
    prev_ov[id] = ov;
  endtask

  always @(negedge clk) begin
    cyc++;
    monitor(0, 8, iv0, ir0, ov0, or0, bz0, s0, {8'h0, a0}, {8'h0, b0}, {16'h0, y0});
    monitor(1, 16, iv1, ir1, ov1, or1, bz1, s1, a1, b1, y1);
  end

  task automatic drive(input int id, input logic v, r, input logic [15:0] a, b, input logic s);
    if (id == 0) begin
      iv0 = v; or0 = r; a0 = a[7:0]; b0 = b[7:0]; s0 = s;
    end else begin
      iv1 = v; or1 = r; a1 = a; b1 = b; s1 = s;
    end
  endtask

  function automatic logic get_ov(input int id);
    return (id == 0) ? ov0 : ov1;
  endfunction

  function automatic logic [31:0] get_y(input int id);
    return (id == 0) ? {16'h0, y0} : y1;
  endfunction

  // Starts and ends at rising edge + 1; the instance must be idle on entry.
  task automatic op(input int id, input logic [15:0] a, b, input logic sg,
                    input logic [31:0] lit, input int lat, input string nm);
    int t;
    drive(id, 1'b1, 1'b1, a, b, sg);
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b1, a, b, sg);
    t = 0;
    while (!get_ov(id) && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check({nm, "_latency"}, t, lat);
    check(nm, get_y(id), lit);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] pick(input int n);
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      2: r = 16'h1 << (n - 1);
      3: r = (16'h1 << (n - 1)) - 16'h1;
      default: ;
    endcase
    if (n == 8) r[15:8] = '0;
    return r;
  endfunction

  task automatic rand_run(input int id, input int n_ops);
    int start, guard, n;
    logic v, r, s;
    logic [15:0] ra, rb;
    n     = (id == 0) ? 8 : 16;
    start = done_cnt[id];
    guard = 0;
    while (done_cnt[id] < start + n_ops && guard < 30000) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 3) != 0);
      s  = 1'($urandom);
      ra = pick(n);
      rb = pick(n);
      drive(id, v, r, ra, rb, s);
      @(posedge clk); #1;
      guard++;
    end
    check("random_progress", 32'(done_cnt[id] - start), 32'(n_ops));
    drive(id, 1'b0, 1'b1, '0, '0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_i = 1'b0;
    drive(0, 1'b0, 1'b1, '0, '0, 1'b0);
    drive(1, 1'b0, 1'b1, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    check("init_in_ready", ir0, 1'b1);
    check("init_out_valid", ov0, 1'b0);
    check("init_busy", bz0, 1'b0);
    check("init_y", y0, 16'h0);

    op(0, 16'h00FD, 16'h0005, 1'b1, 32'hFFF1, 6, "s_m3x5");
    op(0, 16'h00FF, 16'h00FF, 1'b0, 32'hFE01, 6, "u_ffxff");
    op(0, 16'h00FF, 16'h00FF, 1'b1, 32'h0001, 6, "s_ffxff");
    op(0, 16'h0080, 16'h0080, 1'b1, 32'h4000, 6, "s_minxmin");
    op(0, 16'h0000, 16'h0080, 1'b1, 32'h0000, 6, "s_0xmin");

    // Back-pressure: result must hold while new operands are offered.
    or0 = 1'b0;
    a0 = 8'h80; b0 = 8'h7F; s0 = 1'b1; iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    t = 0;
    while (!ov0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_latency", t, 6);
    for (int i = 0; i < 10; i++) begin
      iv0 = i[0];
      a0  = 8'($urandom);
      b0  = 8'($urandom);
      s0  = 1'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", ov0, 1'b1);
      check("bp_y", y0, 16'hC080);
      check("bp_in_ready", ir0, 1'b0);
    end
    iv0 = 1'b0; or0 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", ov0, 1'b0);
    check("bp_release_ready", ir0, 1'b1);
    check("bp_release_y", y0, 16'hC080);

    // Reset during iteration 2 discards the operation.
    a0 = 8'd9; b0 = 8'd9; s0 = 1'b0; iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    check("midrst_in_ready", ir0, 1'b1);
    check("midrst_out_valid", ov0, 1'b0);
    check("midrst_y", y0, 16'h0);
    check("midrst_busy", bz0, 1'b0);
    t = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ov0) t++;
    end
    check("midrst_no_stale_valid", t, 0);
    op(0, 16'h0007, 16'h0006, 1'b1, 32'h002A, 6, "s_7x6");

    fork
      rand_run(0, 1500);
      begin
        op(1, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 10, "w_minxmin");
        op(1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 10, "w_u_ones");
        op(1, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 10, "w_s_ones");
        op(1, 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000, 10, "w_minxmax");
        rand_run(1, 800);
      end
    join

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
